life_step_engine: RTL and testbench

//   Computes the next cellular-automaton generation from the 64-bit board

---
 rtl/life_pkg.sv | 21 ++
 rtl/life_cell_rule.sv | 22 ++
 rtl/life_step_engine.sv | 132 +++++++++++++
 tb/tb_life_step_engine.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared board geometry, FSM state encoding and common rule masks for the
// life step engine and its test environment.
package life_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  localparam logic [8:0] B3_MASK  = 9'h008;
  localparam logic [8:0] S23_MASK = 9'h00C;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_e;

  function automatic int idx(input int r, input int c);
    return COLS * r + c;
  endfunction

endpackage

// File: rtl/life_cell_rule.sv
// One cell of a life-like rule: counts the eight neighbours and looks the
// count up in the birth or survive mask depending on the cell's own state.
module life_cell_rule (
  input  logic [7:0] nbrs_i,
  input  logic       self_i,
  input  logic [8:0] birth_mask_i,
  input  logic [8:0] survive_mask_i,
  output logic       next_o
);

  logic [3:0] count;

  always_comb begin
    count = '0;
    for (int k = 0; k < 8; k++) begin
      count = count + 4'(nbrs_i[k]);
    end
  end

  assign next_o = self_i ? survive_mask_i[count] : birth_mask_i[count];

endmodule

// File: rtl/life_step_engine.sv
// Computes one life-like generation from a snapshot of the board and writes
// it back one row per cycle through the board's row-load port.
module life_step_engine
  import life_pkg::*;
#(
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [63:0]      cells,
  input  logic [8:0]       birth_mask,
  input  logic [8:0]       survive_mask,
  output logic             load_r,
  output logic [2:0]       r_select,
  output logic [7:0]       r_val,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count
);

  state_e           state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [63:0]      snap_q, snap_d;
  logic [8:0]       birth_q, birth_d;
  logic [8:0]       survive_q, survive_d;
  logic [GEN_W-1:0] gen_q, gen_d;

  logic [2:0] rowUp, rowDn;
  logic [7:0] upBits, curBits, dnBits;
  logic [7:0] nextRow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      snap_q    <= '0;
      birth_q   <= '0;
      survive_q <= '0;
      gen_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      snap_q    <= snap_d;
      birth_q   <= birth_d;
      survive_q <= survive_d;
      gen_q     <= gen_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    snap_d    = snap_q;
    birth_d   = birth_q;
    survive_d = survive_q;
    gen_d     = gen_q;
    load_r    = 1'b0;
    r_select  = '0;
    r_val     = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_d    = cells;
          birth_d   = birth_mask;
          survive_d = survive_mask;
          row_d     = '0;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        load_r   = 1'b1;
        r_select = row_q;
        r_val    = nextRow;
        busy     = 1'b1;
        row_d    = row_q + 3'd1;
        if (row_q == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        gen_d   = gen_q + GEN_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row indices wrap naturally in 3 bits; without wrap the off-board row is dead.
  always_comb begin
    rowUp   = row_q - 3'd1;
    rowDn   = row_q + 3'd1;
    upBits  = snap_q[{rowUp, 3'b000} +: 8];
    curBits = snap_q[{row_q, 3'b000} +: 8];
    dnBits  = snap_q[{rowDn, 3'b000} +: 8];
    if (WRAP == 0 && row_q == 3'd0) begin
      upBits = '0;
    end
    if (WRAP == 0 && row_q == 3'd7) begin
      dnBits = '0;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int   CL    = (c + COLS - 1) % COLS;
    localparam int   CR    = (c + 1) % COLS;
    localparam logic HAS_L = (WRAP != 0) || (c != 0);
    localparam logic HAS_R = (WRAP != 0) || (c != COLS - 1);

    logic [7:0] nbrs;

    assign nbrs = {upBits[CL] & HAS_L, upBits[c], upBits[CR] & HAS_R,
                   curBits[CL] & HAS_L, curBits[CR] & HAS_R,
                   dnBits[CL] & HAS_L, dnBits[c], dnBits[CR] & HAS_R};

    life_cell_rule u_rule (
      .nbrs_i         (nbrs),
      .self_i         (curBits[c]),
      .birth_mask_i   (birth_q),
      .survive_mask_i (survive_q),
      .next_o         (nextRow[c])
    );
  end

  assign gen_count = gen_q;

endmodule

// File: tb/tb_life_step_engine.sv
// Self-checking bench for life_step_engine: a toroidal and a bounded instance
// write into bench-held boards, checked against a reference generation model.
module tb_life_step_engine;
  import life_pkg::*;

  typedef struct {
    int row;
    int val;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] cells = '0;
  logic [8:0]  birth_mask = B3_MASK;
  logic [8:0]  survive_mask = S23_MASK;

  logic        loadA, busyA, doneA;
  logic [2:0]  selA;
  logic [7:0]  valA;
  logic [15:0] genA;
  logic        loadB, busyB, doneB;
  logic [2:0]  selB;
  logic [7:0]  valB;
  logic [15:0] genB;

  logic [63:0] boardA = '0;
  logic [63:0] boardB = '0;
  logic [63:0] expA, expB;
  exp_t        expQ[$];
  int          doneRels[$];
  int          rel = 0;
  int          expGen = 0;
  int          errors = 0;
  int          checks = 0;

  life_step_engine #(.WRAP(1), .GEN_W(16)) dutA (
    .clk(clk), .reset_n(reset_n), .start(start), .cells(cells),
    .birth_mask(birth_mask), .survive_mask(survive_mask),
    .load_r(loadA), .r_select(selA), .r_val(valA),
    .busy(busyA), .done(doneA), .gen_count(genA)
  );

  life_step_engine #(.WRAP(0), .GEN_W(16)) dutB (
    .clk(clk), .reset_n(reset_n), .start(start), .cells(cells),
    .birth_mask(birth_mask), .survive_mask(survive_mask),
    .load_r(loadB), .r_select(selB), .r_val(valB),
    .busy(busyB), .done(doneB), .gen_count(genB)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] lifeRef(input logic [63:0] p, input logic [8:0] b,
                                          input logic [8:0] s, input bit wrap);
    logic [63:0] q;
    q = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (wrap) begin
              rr = (rr + ROWS) % ROWS;
              cc = (cc + COLS) % COLS;
            end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
              continue;
            end
            n += int'(p[idx(rr, cc)]);
          end
        end
        q[idx(r, c)] = p[idx(r, c)] ? s[n] : b[n];
      end
    end
    return q;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushRows(input logic [63:0] nextGen, input int firstCyc);
    for (int r = 0; r < ROWS; r++) begin
      exp_t e;
      e.row = r;
      e.val = int'(nextGen[idx(r, 0) +: 8]);
      e.cyc = firstCyc + r;
      expQ.push_back(e);
    end
  endtask

  // One clock period: observe both instances away from the rising edge.
  task automatic sampleCycle();
    @(negedge clk);
    rel++;
    if (loadA) begin
      checkOutput("write expected", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("r_select", 64'(selA), 64'(e.row));
        checkOutput("r_val", 64'(valA), 64'(e.val));
        checkOutput("write cycle", 64'(rel), 64'(e.cyc));
      end
      boardA[{selA, 3'b000} +: 8] = valA;
    end
    if (loadB) begin
      boardB[{selB, 3'b000} +: 8] = valB;
    end
    if (doneA) begin
      doneRels.push_back(rel);
    end
    cells = boardA;
  endtask

  task automatic applyStimulus(input logic [63:0] pattern, input logic [8:0] b,
                               input logic [8:0] s);
    boardA = pattern;
    boardB = pattern;
    cells = pattern;
    birth_mask = b;
    survive_mask = s;
    expA = lifeRef(pattern, b, s, 1'b1);
    expB = lifeRef(pattern, b, s, 1'b0);
    pushRows(expA, 1);
    doneRels.delete();
    rel = 0;
    start = 1'b1;
  endtask

  task automatic runStep(input string tag, input logic [63:0] pattern,
                         input logic [8:0] b, input logic [8:0] s);
    applyStimulus(pattern, b, s);
    sampleCycle();
    start = 1'b0;
    birth_mask = B3_MASK ^ 9'h1FF;
    survive_mask = 9'h000;
    repeat (9) sampleCycle();
    expGen++;
    checkOutput({tag, " rows left"}, 64'(expQ.size()), 64'd0);
    checkOutput({tag, " done pulses"}, 64'(doneRels.size()), 64'd1);
    checkOutput({tag, " done cycle"}, 64'(doneRels.size() > 0 ? doneRels[0] : 0), 64'd9);
    checkOutput({tag, " board wrap"}, boardA, expA);
    checkOutput({tag, " board bounded"}, boardB, expB);
    checkOutput({tag, " gen_count"}, 64'(genA), 64'(expGen));
    checkOutput({tag, " gen_count bounded"}, 64'(genB), 64'(expGen));
    expQ.delete();
  endtask

  initial begin
    logic [63:0] g1, g2;

    repeat (2) @(negedge clk);
    checkOutput("reset load_r", 64'(loadA), 64'd0);
    checkOutput("reset r_select", 64'(selA), 64'd0);
    checkOutput("reset r_val", 64'(valA), 64'd0);
    checkOutput("reset busy", 64'(busyA), 64'd0);
    checkOutput("reset done", 64'(doneA), 64'd0);
    checkOutput("reset gen_count", 64'(genA), 64'd0);
    reset_n = 1'b1;
    repeat (2) sampleCycle();
    checkOutput("idle busy", 64'(busyA), 64'd0);

    runStep("blinker", 64'h0000_0000_1C00_0000, B3_MASK, S23_MASK);
    checkOutput("blinker spec board", boardA, 64'h0000_0008_0808_0000);

    runStep("still", 64'h0000_0000_0000_0303, B3_MASK, S23_MASK);
    checkOutput("still spec board", boardA, 64'h0000_0000_0000_0303);
    checkOutput("still spec gen", 64'(genA), 64'd2);

    runStep("corners", 64'h8100_0000_0000_0081, B3_MASK, S23_MASK);
    checkOutput("corners torus", boardA, 64'h8100_0000_0000_0081);
    checkOutput("corners bounded", boardB, 64'h0);

    runStep("custom", 64'h0000_0000_0800_0000, 9'h002, 9'h000);
    checkOutput("custom spec board", boardA, 64'h0000_001C_141C_0000);

    // start held across 20 rising edges: exactly two back-to-back steps
    g1 = lifeRef(64'h0000_0000_1C00_0000, B3_MASK, S23_MASK, 1'b1);
    g2 = lifeRef(g1, B3_MASK, S23_MASK, 1'b1);
    applyStimulus(64'h0000_0000_1C00_0000, B3_MASK, S23_MASK);
    pushRows(g2, 11);
    repeat (20) sampleCycle();
    start = 1'b0;
    repeat (3) sampleCycle();
    expGen += 2;
    checkOutput("hold rows left", 64'(expQ.size()), 64'd0);
    checkOutput("hold done pulses", 64'(doneRels.size()), 64'd2);
    checkOutput("hold first done", 64'(doneRels.size() > 0 ? doneRels[0] : 0), 64'd9);
    checkOutput("hold second done", 64'(doneRels.size() > 1 ? doneRels[1] : 0), 64'd19);
    checkOutput("hold board", boardA, g2);
    checkOutput("hold gen_count", 64'(genA), 64'(expGen));
    expQ.delete();

    // reset during the fourth write cycle aborts the step
    applyStimulus(64'h0000_0000_1C00_0000, B3_MASK, S23_MASK);
    sampleCycle();
    start = 1'b0;
    repeat (2) sampleCycle();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort load_r", 64'(loadA), 64'd0);
    checkOutput("abort busy", 64'(busyA), 64'd0);
    checkOutput("abort r_val", 64'(valA), 64'd0);
    checkOutput("abort gen_count", 64'(genA), 64'd0);
    checkOutput("abort rows pending", 64'(expQ.size()), 64'd5);
    expQ.delete();
    expGen = 0;
    repeat (3) sampleCycle();
    reset_n = 1'b1;
    repeat (2) sampleCycle();
    checkOutput("abort no done", 64'(doneRels.size()), 64'd0);

    runStep("after abort", boardA, B3_MASK, S23_MASK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
